// File: rtl/powlib_credit_tx_pkg.sv
// Shared types and helpers for the credit-based transmit block.
package powlib_credit_tx_pkg;

  // What the credit counter does on the coming edge.
  typedef enum logic [1:0] {
    CRD_HOLD = 2'd0,
    CRD_TAKE = 2'd1,
    CRD_GIVE = 2'd2,
    CRD_OVF  = 2'd3
  } crd_op_e;

  // Bits needed to hold values 0..value-1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_credit_tx_pipe.sv
// S-stage launch pipe: valid stages clear on reset, data stages are never reset.
module powlib_credit_tx_pipe
  import powlib_credit_tx_pkg::*;
#(
  parameter int W = 16,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  if (S == 0) begin : g_comb
    assign out_vld  = in_vld;
    assign out_data = in_data;
  end else begin : g_reg
    logic [S-1:0] vld_r;
    logic [W-1:0] data_r [S];

    // Valid shift register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_r <= {S{1'b0}};
      end else begin
        vld_r[0] <= in_vld;
        for (int i = 1; i < S; i++) begin
          vld_r[i] <= vld_r[i-1];
        end
      end
    end

    // Data shift register, free running.
    always_ff @(posedge clk) begin
      data_r[0] <= in_data;
      for (int i = 1; i < S; i++) begin
        data_r[i] <= data_r[i-1];
      end
    end

    assign out_vld  = vld_r[S-1];
    assign out_data = data_r[S-1];
  end

endmodule

// File: rtl/powlib_credit_tx.sv
// Credit-based transmitter: issues beats only while holding receiver credits
// and launches them through an S-stage registered pipe.
module powlib_credit_tx
  import powlib_credit_tx_pkg::*;
#(
  parameter int    W    = 16,
  parameter int    CRD  = 8,
  parameter int    S    = 2,
  parameter int    EDBG = 0,
  parameter string ID   = "CRDTX",
  localparam int   CW   = clogb2(CRD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  indata,
  input  logic          invld,
  output logic          inrdy,
  output logic [W-1:0]  outdata,
  output logic          outvld,
  input  logic          crdret,
  output logic [CW-1:0] crdcnt,
  output logic          crderr
);

  localparam logic [CW-1:0] CRD_FULL = CW'(CRD);

  if (CRD < 1) begin : g_bad_crd
    $error("%s: CRD must be at least 1", ID);
  end
  if (S < 0) begin : g_bad_s
    $error("%s: S must not be negative", ID);
  end
  if ((EDBG != 0) && (EDBG != 1)) begin : g_bad_edbg
    $error("%s: EDBG must be 0 or 1", ID);
  end

  logic [CW-1:0] crdcnt_r;
  logic          crderr_r;
  logic          acc_s;
  crd_op_e       op_s;

  // Ready comes only from the registered count, never from crdret.
  assign inrdy = (crdcnt_r != {CW{1'b0}});
  assign acc_s = invld && inrdy;

  // Decode the credit action; a return at full credit is an overflow.
  always_comb begin
    op_s = CRD_HOLD;
    case ({acc_s, crdret})
      2'b10:   op_s = CRD_TAKE;
      2'b01:   op_s = (crdcnt_r == CRD_FULL) ? CRD_OVF : CRD_GIVE;
      default: op_s = CRD_HOLD;
    endcase
  end

  // Credit counter with saturation and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crdcnt_r <= CRD_FULL;
      crderr_r <= 1'b0;
    end else begin
      case (op_s)
        CRD_TAKE: crdcnt_r <= crdcnt_r - CW'(1);
        CRD_GIVE: crdcnt_r <= crdcnt_r + CW'(1);
        CRD_OVF:  crderr_r <= 1'b1;
        default:  crdcnt_r <= crdcnt_r;
      endcase
    end
  end

  assign crdcnt = crdcnt_r;
  assign crderr = crderr_r;

  powlib_credit_tx_pipe #(
    .W (W),
    .S (S)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (acc_s),
    .in_data  (indata),
    .out_vld  (outvld),
    .out_data (outdata)
  );

endmodule

// File: tb/tb_powlib_credit_tx.sv
// Self-checking bench for powlib_credit_tx: per-cycle model compare on an
// S=2/CRD=4 instance plus directed checks on an S=0/CRD=1 instance.
module tb_powlib_credit_tx;

  localparam int CRD_A = 4;
  localparam int S_A   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_indata, a_outdata;
  logic        a_invld, a_inrdy, a_outvld, a_crdret, a_crderr;
  logic [2:0]  a_crdcnt;

  logic [15:0] b_indata, b_outdata;
  logic        b_invld, b_inrdy, b_outvld, b_crdret, b_crderr;
  logic [0:0]  b_crdcnt;

  powlib_credit_tx #(.W(16), .CRD(CRD_A), .S(S_A), .EDBG(0), .ID("CRDTX_A")) u_dut_a (
    .clk(clk), .rst(rst), .indata(a_indata), .invld(a_invld), .inrdy(a_inrdy),
    .outdata(a_outdata), .outvld(a_outvld), .crdret(a_crdret),
    .crdcnt(a_crdcnt), .crderr(a_crderr)
  );

  powlib_credit_tx #(.W(16), .CRD(1), .S(0), .EDBG(0), .ID("CRDTX_B")) u_dut_b (
    .clk(clk), .rst(rst), .indata(b_indata), .invld(b_invld), .inrdy(b_inrdy),
    .outdata(b_outdata), .outvld(b_outvld), .crdret(b_crdret),
    .crdcnt(b_crdcnt), .crderr(b_crderr)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } beat_t;

  beat_t q[$];
  int    cyc     = 0;
  int    m_cnt   = CRD_A;
  bit    m_err   = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    seen    = 0;
  bit    m_acc;
  bit    exp_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: credits are a plain integer, accepted beats are scheduled S cycles out.
  always @(posedge clk) begin
    if (!rst) begin
      m_cnt <= CRD_A;
      m_err <= 1'b0;
    end else if (a_invld && (m_cnt != 0) && !a_crdret) begin
      m_cnt <= m_cnt - 1;
    end else if (a_crdret && !(a_invld && (m_cnt != 0))) begin
      if (m_cnt == CRD_A) m_err <= 1'b1;
      else                m_cnt <= m_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  // Compare DUT A against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      chk("rst_outvld", 32'(a_outvld), 32'd0);
      chk("rst_crdcnt", 32'(a_crdcnt), 32'(CRD_A));
      chk("rst_crderr", 32'(a_crderr), 32'd0);
    end else begin
      m_acc = a_invld && (m_cnt != 0);
      if (m_acc) q.push_back('{due: cyc + S_A, data: a_indata});
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("inrdy",  32'(a_inrdy),  32'(m_cnt != 0));
      chk("crdcnt", 32'(a_crdcnt), 32'(m_cnt));
      chk("crderr", 32'(a_crderr), 32'(m_err));
      chk("outvld", 32'(a_outvld), 32'(exp_v));
      if (exp_v) begin
        chk("outdata", 32'(a_outdata), 32'(q[0].data));
        void'(q.pop_front());
      end
      if (a_outvld) seen++;
    end
  end

  task automatic step(input logic v, input logic [15:0] d, input logic cr);
    a_invld  = v;
    a_indata = d;
    a_crdret = cr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_invld = 1'b0; a_indata = 16'h0000; a_crdret = 1'b0;
    b_invld = 1'b0; b_indata = 16'h0000; b_crdret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_crdcnt", 32'(a_crdcnt), 32'd4);
    chk("reset_inrdy",  32'(a_inrdy),  32'd1);
    chk("reset_outvld", 32'(a_outvld), 32'd0);
    rst = 1'b1;

    // Burst with no returns: four beats then stall.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
    chk("burst_seen",   32'(seen),     32'd4);
    chk("burst_crdcnt", 32'(a_crdcnt), 32'd0);
    chk("burst_inrdy",  32'(a_inrdy),  32'd0);

    // Single return from empty.
    step(1'b0, 16'h0000, 1'b1);
    chk("ret1_crdcnt", 32'(a_crdcnt), 32'd1);
    chk("ret1_inrdy",  32'(a_inrdy),  32'd1);
    step(1'b1, 16'h2000, 1'b0);
    chk("ret1_use", 32'(a_crdcnt), 32'd0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("ret1_seen", 32'(seen), 32'd5);

    // Steady state: accept and return every cycle.
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk("steady_pre", 32'(a_crdcnt), 32'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h3000 + 16'(i), 1'b1);
    chk("steady_crdcnt", 32'(a_crdcnt), 32'd2);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("steady_seen", 32'(seen), 32'd15);

    // Overflow at full credit.
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk("full_crdcnt", 32'(a_crdcnt), 32'd4);
    step(1'b0, 16'h0000, 1'b1);
    chk("ovf_crdcnt", 32'(a_crdcnt), 32'd4);
    chk("ovf_crderr", 32'(a_crderr), 32'd1);
    step(1'b1, 16'h4000, 1'b0);
    step(1'b1, 16'h4001, 1'b0);
    chk("ovf_sticky", 32'(a_crderr), 32'd1);
    chk("ovf_cnt2",   32'(a_crdcnt), 32'd2);

    // Asynchronous reset with the pipe full.
    a_invld = 1'b0;
    chk("inflight_vld", 32'(a_outvld), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_outvld", 32'(a_outvld), 32'd0);
    chk("async_crdcnt", 32'(a_crdcnt), 32'd4);
    chk("async_crderr", 32'(a_crderr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("post_crdcnt", 32'(a_crdcnt), 32'd4);
    chk("post_crderr", 32'(a_crderr), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0);
    chk("post_seen", 32'(seen), 32'd15);

    // Pass-through instance, single credit.
    b_invld  = 1'b1;
    b_indata = 16'hA5A5;
    #1;
    chk("b_outvld",  32'(b_outvld),  32'd1);
    chk("b_outdata", 32'(b_outdata), 32'h0000A5A5);
    chk("b_inrdy",   32'(b_inrdy),   32'd1);
    @(posedge clk);
    #1;
    chk("b_inrdy_next", 32'(b_inrdy),  32'd0);
    chk("b_outvld_off", 32'(b_outvld), 32'd0);
    chk("b_crdcnt0",    32'(b_crdcnt), 32'd0);
    b_crdret = 1'b1;
    #1;
    chk("b_ret_same", 32'(b_inrdy), 32'd0);
    @(posedge clk);
    #1;
    b_crdret = 1'b0;
    b_indata = 16'h5A5A;
    #1;
    chk("b_ret_cnt",  32'(b_crdcnt),  32'd1);
    chk("b_ret_rdy",  32'(b_inrdy),   32'd1);
    chk("b_ret_vld",  32'(b_outvld),  32'd1);
    chk("b_ret_data", 32'(b_outdata), 32'h00005A5A);
    @(posedge clk);
    #1;
    b_invld = 1'b0;
    chk("b_end_cnt", 32'(b_crdcnt), 32'd0);
    chk("b_end_err", 32'(b_crderr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
